// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC SPI serialiser.
// Used by dac_spi_driver and the optional dac_amp_scaler.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } dac_state_t;

    localparam int          FRAME_BITS          = 16;
    localparam logic [3:0]  CTRL_NIBBLE_DEFAULT = 4'b0011;
    localparam logic [7:0]  MIDSCALE            = 8'h80;

    // DAC write word: command nibble, sample, four don't-care zero bits.
    function automatic logic [FRAME_BITS-1:0] build_word(input logic [3:0] ctrl,
                                                         input logic [7:0] sample);
        return {ctrl, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_amp_scaler.sv
// Combinational amplitude scaler about mid-scale (1x/0.5x/0.25x/0.125x).
// Only instantiated when DAC_AMP_SCALE_EN is defined.
module dac_amp_scaler
    import dac_pkg::*;
(
    input  logic [7:0] sample_in,
    input  logic [1:0] amp_shift,
    output logic [7:0] sample_out
);

    logic signed [9:0] diff;
    logic signed [9:0] scaled;
    logic signed [9:0] sum;

    always_comb begin
        diff   = signed'({2'b00, sample_in}) - signed'({2'b00, MIDSCALE});
        scaled = diff >>> amp_shift;
        sum    = scaled + signed'({2'b00, MIDSCALE});
        if (sum < 10'sd0) begin
            sample_out = 8'h00;
        end else if (sum > 10'sd255) begin
            sample_out = 8'hFF;
        end else begin
            sample_out = sum[7:0];
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises accepted 8-bit samples as 16-bit SPI writes to a serial DAC.
// Optional DAC_AMP_SCALE_EN adds amp_shift and scales the sample about mid-scale.
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [3:0]  CTRL_NIBBLE = CTRL_NIBBLE_DEFAULT
) (
    input  logic       clk_100kHz,
    input  logic       rst_,
    input  logic [7:0] sample_in,
`ifdef DAC_AMP_SCALE_EN
    input  logic [1:0] amp_shift,
`endif
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] BIT_RELOAD = 4'(FRAME_BITS - 1);

    dac_state_t              state_reg, state_next;
    logic [7:0]              phase_reg, phase_next;
    logic [3:0]              bit_reg, bit_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic                    cs_n_reg, cs_n_next;
    logic                    sclk_reg, sclk_next;
    logic                    mosi_reg, mosi_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    ready_reg, ready_next;
    logic [7:0]              sample_latched;

`ifdef DAC_AMP_SCALE_EN
    dac_amp_scaler u_scaler (
        .sample_in  (sample_in),
        .amp_shift  (amp_shift),
        .sample_out (sample_latched)
    );
`else
    assign sample_latched = sample_in;
`endif

    always_ff @(posedge clk_100kHz) begin
        if (rst_) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            cs_n_reg  <= cs_n_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
        end
    end

    // The phase counter doubles as the inter-frame gap timer.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (sample_valid && ready_reg) begin
                    state_next = SHIFT_LO;
                    phase_next = DIV_RELOAD;
                    bit_next   = BIT_RELOAD;
                    shift_next = build_word(CTRL_NIBBLE, sample_latched);
                end
            end
            SHIFT_LO: begin
                if (phase_reg == 8'd0) begin
                    state_next = SHIFT_HI;
                    phase_next = DIV_RELOAD;
                end else begin
                    phase_next = phase_reg - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_reg == 8'd0) begin
                    if (bit_reg == 4'd0) begin
                        state_next = GAP;
                        phase_next = GAP_RELOAD;
                        shift_next = '0;
                    end else begin
                        state_next = SHIFT_LO;
                        phase_next = DIV_RELOAD;
                        bit_next   = bit_reg - 4'd1;
                        shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    phase_next = phase_reg - 8'd1;
                end
            end
            GAP: begin
                if (phase_reg == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    phase_next = phase_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        cs_n_next  = 1'b1;
        sclk_next  = 1'b0;
        mosi_next  = 1'b0;
        busy_next  = (state_next != IDLE);
        ready_next = (state_next == IDLE);
        done_next  = (state_reg == SHIFT_HI) && (state_next == GAP);
        if (state_next == SHIFT_LO || state_next == SHIFT_HI) begin
            cs_n_next = 1'b0;
            sclk_next = (state_next == SHIFT_HI);
            mosi_next = shift_next[FRAME_BITS-1];
        end
    end

    assign sample_ready = ready_reg;
    assign dac_cs_n     = cs_n_reg;
    assign dac_sclk     = sclk_reg;
    assign dac_mosi     = mosi_reg;
    assign busy         = busy_reg;
    assign frame_done   = done_reg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Randomised self-checking bench for dac_spi_driver (default and CLK_DIV=3 instances).
// Define DAC_AMP_SCALE_EN to also exercise amplitude scaling.
module tb_dac_spi_driver;

    logic       clk_100kHz = 1'b0;
    logic       rst_;
    logic [7:0] sample_in;
    logic       drv_valid;
    logic       sel;
    int         cur_shift = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_100kHz = ~clk_100kHz;

    wire valid_a = drv_valid & ~sel;
    wire valid_b = drv_valid & sel;

    wire a_ready, a_cs_n, a_sclk, a_mosi, a_busy, a_done;
    wire b_ready, b_cs_n, b_sclk, b_mosi, b_busy, b_done;

`ifdef DAC_AMP_SCALE_EN
    logic [1:0] amp_shift;
    assign amp_shift = 2'(cur_shift);
`endif

    dac_spi_driver dut_a (
        .clk_100kHz   (clk_100kHz),
        .rst_         (rst_),
        .sample_in    (sample_in),
`ifdef DAC_AMP_SCALE_EN
        .amp_shift    (amp_shift),
`endif
        .sample_valid (valid_a),
        .sample_ready (a_ready),
        .dac_cs_n     (a_cs_n),
        .dac_sclk     (a_sclk),
        .dac_mosi     (a_mosi),
        .busy         (a_busy),
        .frame_done   (a_done)
    );

    dac_spi_driver #(.CLK_DIV(3), .GAP_CYCLES(3)) dut_b (
        .clk_100kHz   (clk_100kHz),
        .rst_         (rst_),
        .sample_in    (sample_in),
`ifdef DAC_AMP_SCALE_EN
        .amp_shift    (amp_shift),
`endif
        .sample_valid (valid_b),
        .sample_ready (b_ready),
        .dac_cs_n     (b_cs_n),
        .dac_sclk     (b_sclk),
        .dac_mosi     (b_mosi),
        .busy         (b_busy),
        .frame_done   (b_done)
    );

    wire mon_ready = sel ? b_ready : a_ready;
    wire mon_cs_n  = sel ? b_cs_n  : a_cs_n;
    wire mon_sclk  = sel ? b_sclk  : a_sclk;
    wire mon_mosi  = sel ? b_mosi  : a_mosi;
    wire mon_busy  = sel ? b_busy  : a_busy;
    wire mon_done  = sel ? b_done  : a_done;

    task automatic step();
        @(negedge clk_100kHz);
    endtask

    // Reference: command nibble 0011, scaled sample (floor of signed shift), four zeros.
    function automatic logic [15:0] model_word(input logic [7:0] s, input int sh);
        int d, q, v, p;
        d = int'(s) - 128;
        p = 1 << sh;
        if (d >= 0) q = d / p;
        else        q = -((-d + p - 1) / p);
        v = 128 + q;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return {4'b0011, 8'(v), 4'b0000};
    endfunction

    // Offers one sample to an idle DUT and measures the whole resulting frame.
    task automatic run_frame(input logic [7:0] s, input int div, input int gap,
                             input logic [15:0] expw, input string tag);
        int cs_first = -1, cs_last = -1, cs_cnt = 0;
        int done_cnt = 0, done_at = -1, ready_at = -1;
        int nbits = 0, hi_run = 0, bad_run = 0;
        logic [15:0] word = '0;
        logic prev_sclk = 1'b0;
        checks++;
        if (mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", tag, mon_ready);
        end
        sample_in = s;
        drv_valid = 1'b1;
        step();
        drv_valid = 1'b0;
        for (int k = 1; k <= 1 + 32*div + gap + 2; k++) begin
            if (mon_cs_n === 1'b0) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = k;
                cs_last = k;
            end
            if (mon_sclk === 1'b1 && prev_sclk === 1'b0) begin
                word = {word[14:0], mon_mosi};
                nbits++;
            end
            if (mon_sclk === 1'b1) hi_run++;
            else begin
                if (hi_run != 0 && hi_run != div) bad_run++;
                hi_run = 0;
            end
            if (mon_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (mon_ready === 1'b1 && ready_at < 0) ready_at = k;
            prev_sclk = mon_sclk;
            sample_in = 8'($urandom);
            step();
        end
        $display("frame %s sample %h word %h bits %0d cs_low %0d done_at %0d ready_at %0d",
                 tag, s, word, nbits, cs_cnt, done_at, ready_at);
        checks++;
        if (word !== expw || nbits != 16) begin
            errors++;
            $display("FAIL %s word got %h (%0d bits) want %h (16 bits)", tag, word, nbits, expw);
        end
        checks++;
        if (cs_first != 1 || cs_last != 32*div || cs_cnt != 32*div) begin
            errors++;
            $display("FAIL %s cs_window got %0d..%0d cnt %0d want 1..%0d", tag, cs_first, cs_last, cs_cnt, 32*div);
        end
        checks++;
        if (done_cnt != 1 || done_at != 32*div + 1) begin
            errors++;
            $display("FAIL %s frame_done got %0d pulses at %0d want 1 at %0d", tag, done_cnt, done_at, 32*div + 1);
        end
        checks++;
        if (ready_at != 1 + 32*div + gap) begin
            errors++;
            $display("FAIL %s ready_return got %0d want %0d", tag, ready_at, 1 + 32*div + gap);
        end
        checks++;
        if (bad_run != 0) begin
            errors++;
            $display("FAIL %s sclk_high_period got %0d bad runs want 0", tag, bad_run);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({mon_cs_n, mon_sclk, mon_mosi, mon_ready, mon_busy, mon_done} !== 6'b100100) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got %b want 100100", i,
                         {mon_cs_n, mon_sclk, mon_mosi, mon_ready, mon_busy, mon_done});
            end
            step();
        end
        rst_ = 1'b1;
        drv_valid = 1'b1;
        sample_in = 8'($urandom);
        step();
        rst_ = 1'b0;
        drv_valid = 1'b0;
        step();
        checks++;
        if (mon_cs_n !== 1'b1 || mon_busy !== 1'b0 || mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority got cs_n %b busy %b ready %b want 1 0 1", mon_cs_n, mon_busy, mon_ready);
        end
        $display("reset priority over handshake: cs_n %b busy %b", mon_cs_n, mon_busy);
    endtask

    task automatic test_frames();
        logic [7:0] s;
        run_frame(8'hA5, 1, 2, model_word(8'hA5, 0), "defaults_A5");
        for (int i = 0; i < 5; i++) begin
            s = 8'($urandom);
            run_frame(s, 1, 2, model_word(s, 0), "random");
        end
    endtask

    task automatic test_clkdiv();
        sel = 1'b1;
        step();
        run_frame(8'hFF, 3, 3, model_word(8'hFF, 0), "clkdiv3_FF");
        sel = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] start;
        int falls[$];
        logic [15:0] words[$];
        logic [15:0] word = '0;
        logic prev_cs = 1'b1, prev_sclk = 1'b0;
        start = 8'($urandom);
        for (int n = 0; n < 150; n++) begin
            sample_in = start + 8'(n);
            drv_valid = 1'b1;
            step();
            if (mon_cs_n === 1'b0 && prev_cs === 1'b1) falls.push_back(n);
            if (mon_sclk === 1'b1 && prev_sclk === 1'b0) word = {word[14:0], mon_mosi};
            if (mon_done === 1'b1) words.push_back(word);
            prev_cs = mon_cs_n;
            prev_sclk = mon_sclk;
        end
        drv_valid = 1'b0;
        checks++;
        if (falls.size() != 5 || words.size() != 4) begin
            errors++;
            $display("FAIL b2b_counts got %0d starts %0d frames want 5 starts 4 frames", falls.size(), words.size());
        end
        for (int i = 0; i < 5 && i < falls.size(); i++) begin
            checks++;
            if (falls[i] != 35*i) begin
                errors++;
                $display("FAIL b2b_start %0d got cycle %0d want %0d", i, falls[i], 35*i);
            end
        end
        for (int i = 0; i < words.size(); i++) begin
            $display("b2b frame %0d word %h", i, words[i]);
            checks++;
            if (words[i] !== model_word(start + 8'(35*i), 0)) begin
                errors++;
                $display("FAIL b2b_word %0d got %h want %h", i, words[i], model_word(start + 8'(35*i), 0));
            end
        end
        repeat (40) step();
    endtask

    task automatic test_reset_midframe();
        sample_in = 8'($urandom);
        drv_valid = 1'b1;
        step();
        drv_valid = 1'b0;
        repeat (9) step();
        checks++;
        if (mon_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL midframe_active got cs_n %b want 0", mon_cs_n);
        end
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
        checks++;
        if ({mon_cs_n, mon_sclk, mon_mosi, mon_ready, mon_busy, mon_done} !== 6'b100100) begin
            errors++;
            $display("FAIL midframe_reset got %b want 100100",
                     {mon_cs_n, mon_sclk, mon_mosi, mon_ready, mon_busy, mon_done});
        end
        $display("midframe reset: cs_n %b sclk %b ready %b", mon_cs_n, mon_sclk, mon_ready);
        run_frame(8'h00, 1, 2, model_word(8'h00, 0), "after_reset_00");
    endtask

`ifdef DAC_AMP_SCALE_EN
    task automatic test_amp();
        logic [7:0] s;
        cur_shift = 1;
        run_frame(8'hFF, 1, 2, model_word(8'hFF, 1), "amp1_FF");
        run_frame(8'h00, 1, 2, model_word(8'h00, 1), "amp1_00");
        for (int i = 0; i < 6; i++) begin
            s = 8'($urandom);
            cur_shift = int'($urandom_range(0, 3));
            run_frame(s, 1, 2, model_word(s, cur_shift), "amp_random");
        end
        cur_shift = 0;
    endtask
`endif

    initial begin
        rst_ = 1'b1;
        drv_valid = 1'b0;
        sel = 1'b0;
        sample_in = 8'h00;
        repeat (3) step();
        rst_ = 1'b0;
        test_reset();
        test_frames();
        test_clkdiv();
        test_back_to_back();
        test_reset_midframe();
`ifdef DAC_AMP_SCALE_EN
        test_amp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
